// File: rtl/traffic_test_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_test_pkg
// Description : Shared constants and helpers for the traffic test run
//               controller: run-sequencer state encoding and width helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_test_pkg;

    localparam int c_state_width = 3;

    localparam logic [c_state_width-1:0] c_st_idle  = 3'd0;
    localparam logic [c_state_width-1:0] c_st_clear = 3'd1;
    localparam logic [c_state_width-1:0] c_st_run   = 3'd2;
    localparam logic [c_state_width-1:0] c_st_drain = 3'd3;
    localparam logic [c_state_width-1:0] c_st_done  = 3'd4;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int sel_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_port_counter.sv
`default_nettype none
// ============================================================================
// Module      : traffic_port_counter
// Description : Per-port beat accounting for one generator/checker pair.
//               Counts accepted generator beats and consumed checker beats
//               against the latched beat target and flags completion and
//               overrun.
// Ports       : clk, rst_n        clock, async active-low reset
//               i_clear           synchronous zeroing of both counters
//               i_tx_inc/i_rx_inc count strobes (already qualified)
//               i_beats           beat target for this run
//               o_tx_cnt/o_rx_cnt counter values
//               o_tx_done         tx_cnt == beats
//               o_rx_done         rx_cnt >= beats
//               o_overrun         rx_cnt >  beats
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_port_counter #(
    parameter int C_COUNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_tx_inc,
    input  logic                     i_rx_inc,
    input  logic [C_COUNT_WIDTH-1:0] i_beats,
    output logic [C_COUNT_WIDTH-1:0] o_tx_cnt,
    output logic [C_COUNT_WIDTH-1:0] o_rx_cnt,
    output logic                     o_tx_done,
    output logic                     o_rx_done,
    output logic                     o_overrun
);

    localparam logic [C_COUNT_WIDTH-1:0] c_one = C_COUNT_WIDTH'(1);

    logic [C_COUNT_WIDTH-1:0] r_tx_cnt;
    logic [C_COUNT_WIDTH-1:0] r_rx_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else if (i_clear) begin
            r_tx_cnt <= '0;
            r_rx_cnt <= '0;
        end else begin
            // tx increments are gated by gen_enable upstream, so the tx
            // counter stops at the target and cannot wrap.
            if (i_tx_inc) begin
                r_tx_cnt <= r_tx_cnt + c_one;
            end
            // A misbehaving checker may keep reading; hold at all-ones so the
            // overrun verdict cannot be lost to wrap-around.
            if (i_rx_inc && (r_rx_cnt != '1)) begin
                r_rx_cnt <= r_rx_cnt + c_one;
            end
        end
    end

    assign o_tx_cnt  = r_tx_cnt;
    assign o_rx_cnt  = r_rx_cnt;
    assign o_tx_done = (r_tx_cnt == i_beats);
    assign o_rx_done = (r_rx_cnt >= i_beats);
    assign o_overrun = (r_rx_cnt >  i_beats);

endmodule
`default_nettype wire

// File: rtl/traffic_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_test_ctrl
// Description : Run controller for a bank of LFSR frame generator/checker
//               pairs. Clears the pairs, enables masked generators for exactly
//               cfg_beats accepted beats, waits for the checkers to drain and
//               latches a pass/fail verdict.
// Ports       : axi_aclk/axi_resetn        clock, async active-low reset
//               start/abort                host run control pulses
//               cfg_beats/cfg_port_mask/cfg_timeout  run config, sampled at start
//               gen_clear/gen_enable       controls to the gen/check pairs
//               tx_beat/rx_beat/err_count  activity and errors from the pairs
//               busy/done/pass/timeout_flag/fail_mask  run status
//               stat_sel/stat_tx_count/stat_rx_count   registered counter readout
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_test_ctrl
    import traffic_test_pkg::*;
#(
    parameter int C_NUM_PORTS     = 4,
    parameter int C_COUNT_WIDTH   = 32,
    parameter int C_TIMEOUT_WIDTH = 24,
    parameter int C_CLEAR_CYCLES  = 8,
    parameter int C_ERR_WIDTH     = 8
) (
    input  logic                               axi_aclk,
    input  logic                               axi_resetn,
    input  logic                               start,
    input  logic                               abort,
    input  logic [C_COUNT_WIDTH-1:0]           cfg_beats,
    input  logic [C_NUM_PORTS-1:0]             cfg_port_mask,
    input  logic [C_TIMEOUT_WIDTH-1:0]         cfg_timeout,
    output logic                               gen_clear,
    output logic [C_NUM_PORTS-1:0]             gen_enable,
    input  logic [C_NUM_PORTS-1:0]             tx_beat,
    input  logic [C_NUM_PORTS-1:0]             rx_beat,
    input  logic [C_NUM_PORTS*C_ERR_WIDTH-1:0] err_count,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic                               timeout_flag,
    output logic [C_NUM_PORTS-1:0]             fail_mask,
    input  logic [sel_width(C_NUM_PORTS)-1:0]  stat_sel,
    output logic [C_COUNT_WIDTH-1:0]           stat_tx_count,
    output logic [C_COUNT_WIDTH-1:0]           stat_rx_count
);

    localparam int c_sel_width = sel_width(C_NUM_PORTS);
    localparam int c_clr_width = sel_width(C_CLEAR_CYCLES);
    localparam logic [c_clr_width-1:0]     c_clr_last = c_clr_width'(C_CLEAR_CYCLES - 1);
    localparam logic [c_clr_width-1:0]     c_clr_one  = c_clr_width'(1);
    localparam logic [C_TIMEOUT_WIDTH-1:0] c_to_one   = C_TIMEOUT_WIDTH'(1);

    // Reset: asserts asynchronously, releases synchronously to axi_aclk.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic [c_state_width-1:0]   r_state;
    logic [c_state_width-1:0]   w_state_nxt;
    logic [C_COUNT_WIDTH-1:0]   r_beats;
    logic [C_NUM_PORTS-1:0]     r_mask;
    logic [C_TIMEOUT_WIDTH-1:0] r_timeout;
    logic [c_clr_width-1:0]     r_clr_cnt;
    logic [C_TIMEOUT_WIDTH-1:0] r_to_cnt;
    logic [C_TIMEOUT_WIDTH-1:0] w_to_next;
    logic                       r_done;
    logic                       r_pass;
    logic                       r_timeout_flag;
    logic [C_NUM_PORTS-1:0]     r_fail_mask;
    logic [C_COUNT_WIDTH-1:0]   r_stat_tx;
    logic [C_COUNT_WIDTH-1:0]   r_stat_rx;

    logic                       w_cnt_clear;
    logic                       w_enter_done;
    logic                       w_timeout_hit;
    logic                       w_rx_active;
    logic                       w_all_tx_done;
    logic                       w_all_rx_done;
    logic [C_NUM_PORTS-1:0]     w_gen_enable;
    logic [C_NUM_PORTS-1:0]     w_tx_done;
    logic [C_NUM_PORTS-1:0]     w_rx_done;
    logic [C_NUM_PORTS-1:0]     w_overrun;
    logic [C_NUM_PORTS-1:0]     w_fail_mask;
    logic [C_COUNT_WIDTH-1:0]   w_tx_cnt [C_NUM_PORTS];
    logic [C_COUNT_WIDTH-1:0]   w_rx_cnt [C_NUM_PORTS];
    logic [C_COUNT_WIDTH-1:0]   w_stat_tx;
    logic [C_COUNT_WIDTH-1:0]   w_stat_rx;

    // Enables are decoded purely from registered state so that no path
    // exists from tx_beat back to gen_enable.
    assign w_gen_enable = (r_state == c_st_run) ? (r_mask & ~w_tx_done) : '0;
    assign w_rx_active  = (r_state == c_st_run) || (r_state == c_st_drain);

    // Unmasked ports count as finished, so an empty mask completes at once.
    assign w_all_tx_done = &(w_tx_done | ~r_mask);
    assign w_all_rx_done = &(w_rx_done | ~r_mask);

    generate
        for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_port
            traffic_port_counter #(
                .C_COUNT_WIDTH (C_COUNT_WIDTH)
            ) u_port_counter (
                .clk       (axi_aclk),
                .rst_n     (w_rst_n),
                .i_clear   (w_cnt_clear),
                .i_tx_inc  (tx_beat[gi] && w_gen_enable[gi]),
                .i_rx_inc  (rx_beat[gi] && r_mask[gi] && w_rx_active),
                .i_beats   (r_beats),
                .o_tx_cnt  (w_tx_cnt[gi]),
                .o_rx_cnt  (w_rx_cnt[gi]),
                .o_tx_done (w_tx_done[gi]),
                .o_rx_done (w_rx_done[gi]),
                .o_overrun (w_overrun[gi])
            );

            assign w_fail_mask[gi] = r_mask[gi] &&
                                     ((err_count[gi*C_ERR_WIDTH +: C_ERR_WIDTH] != '0) ||
                                      (w_rx_cnt[gi] != r_beats) ||
                                      w_overrun[gi]);
        end
    endgenerate

    assign w_to_next = r_to_cnt + c_to_one;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_clear   = 1'b0;
        w_enter_done  = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_st_idle, c_st_done: begin
                if (start) begin
                    w_state_nxt = c_st_clear;
                    w_cnt_clear = 1'b1;
                end
            end
            c_st_clear: begin
                if (r_clr_cnt == c_clr_last) begin
                    w_state_nxt = c_st_run;
                end
            end
            c_st_run: begin
                if (w_all_tx_done) begin
                    w_state_nxt = c_st_drain;
                end
            end
            c_st_drain: begin
                // Successful drain takes precedence over a coincident timeout.
                if (w_all_rx_done) begin
                    w_state_nxt  = c_st_done;
                    w_enter_done = 1'b1;
                end else if ((r_timeout != '0) && (w_to_next == r_timeout)) begin
                    w_state_nxt   = c_st_done;
                    w_enter_done  = 1'b1;
                    w_timeout_hit = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (abort) begin
            w_state_nxt   = c_st_idle;
            w_cnt_clear   = 1'b0;
            w_enter_done  = 1'b0;
            w_timeout_hit = 1'b0;
        end
    end

    always_comb begin
        w_stat_tx = '0;
        w_stat_rx = '0;
        for (int i = 0; i < C_NUM_PORTS; i++) begin
            if (stat_sel == c_sel_width'(i)) begin
                w_stat_tx = w_tx_cnt[i];
                w_stat_rx = w_rx_cnt[i];
            end
        end
    end

    always_ff @(posedge axi_aclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= c_st_idle;
            r_beats        <= '0;
            r_mask         <= '0;
            r_timeout      <= '0;
            r_clr_cnt      <= '0;
            r_to_cnt       <= '0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_fail_mask    <= '0;
            r_stat_tx      <= '0;
            r_stat_rx      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= (r_state == c_st_clear) ? (r_clr_cnt + c_clr_one) : '0;
            // Counts completed DRAIN cycles; zero on every DRAIN entry.
            r_to_cnt  <= (r_state == c_st_drain) ? w_to_next : '0;

            if (w_cnt_clear) begin
                r_beats        <= cfg_beats;
                r_mask         <= cfg_port_mask;
                r_timeout      <= cfg_timeout;
                r_done         <= 1'b0;
                r_pass         <= 1'b0;
                r_timeout_flag <= 1'b0;
                r_fail_mask    <= '0;
            end

            if (w_enter_done) begin
                r_done         <= 1'b1;
                r_pass         <= (w_fail_mask == '0) && !w_timeout_hit;
                r_timeout_flag <= w_timeout_hit;
                r_fail_mask    <= w_fail_mask;
            end

            if (abort) begin
                r_done <= 1'b0;
            end

            r_stat_tx <= w_stat_tx;
            r_stat_rx <= w_stat_rx;
        end
    end

    assign gen_clear     = (r_state == c_st_idle) || (r_state == c_st_clear);
    assign gen_enable    = w_gen_enable;
    assign busy          = (r_state != c_st_idle) && (r_state != c_st_done);
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout_flag  = r_timeout_flag;
    assign fail_mask     = r_fail_mask;
    assign stat_tx_count = r_stat_tx;
    assign stat_rx_count = r_stat_rx;

endmodule
`default_nettype wire

// File: tb/tb_traffic_test_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_test_ctrl
// Description : Directed self-checking bench for traffic_test_ctrl. Generator
//               traffic follows gen_enable (optionally gapped); checker reads
//               echo accepted beats five cycles later or arrive immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_test_ctrl;

    localparam int NP = 4;
    localparam int CW = 32;
    localparam int TW = 24;
    localparam int EW = 8;

    logic            axi_aclk      = 1'b0;
    logic            axi_resetn    = 1'b0;
    logic            start         = 1'b0;
    logic            abort         = 1'b0;
    logic [CW-1:0]   cfg_beats     = '0;
    logic [NP-1:0]   cfg_port_mask = '0;
    logic [TW-1:0]   cfg_timeout   = '0;
    logic            gen_clear;
    logic [NP-1:0]   gen_enable;
    logic [NP-1:0]   tx_beat       = '0;
    logic [NP-1:0]   rx_beat       = '0;
    logic [NP*EW-1:0] err_count    = '0;
    logic            busy;
    logic            done;
    logic            pass;
    logic            timeout_flag;
    logic [NP-1:0]   fail_mask;
    logic [1:0]      stat_sel      = '0;
    logic [CW-1:0]   stat_tx_count;
    logic [CW-1:0]   stat_rx_count;

    traffic_test_ctrl #(
        .C_NUM_PORTS     (NP),
        .C_COUNT_WIDTH   (CW),
        .C_TIMEOUT_WIDTH (TW),
        .C_CLEAR_CYCLES  (8),
        .C_ERR_WIDTH     (EW)
    ) dut (
        .axi_aclk      (axi_aclk),
        .axi_resetn    (axi_resetn),
        .start         (start),
        .abort         (abort),
        .cfg_beats     (cfg_beats),
        .cfg_port_mask (cfg_port_mask),
        .cfg_timeout   (cfg_timeout),
        .gen_clear     (gen_clear),
        .gen_enable    (gen_enable),
        .tx_beat       (tx_beat),
        .rx_beat       (rx_beat),
        .err_count     (err_count),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout_flag  (timeout_flag),
        .fail_mask     (fail_mask),
        .stat_sel      (stat_sel),
        .stat_tx_count (stat_tx_count),
        .stat_rx_count (stat_rx_count)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_compared   = 0;
    int n_mismatched = 0;

    int tx_sent  [NP];
    int rx_sent  [NP];
    int rx_limit [NP];
    int n_en     [NP];
    bit rx_imm   [NP];
    bit tx_gap   [NP];
    int n_clr;
    int n_post;
    int cyc = 0;
    logic [NP-1:0] pipe [5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and drive this cycle's strobes.
    task automatic cycle();
        logic [NP-1:0] tv;
        logic [NP-1:0] rv;
        @(posedge axi_aclk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        cyc++;
        if (busy && gen_clear) n_clr++;
        if (busy && !gen_clear && (gen_enable == '0)) n_post++;
        for (int i = 0; i < NP; i++) begin
            tv[i] = gen_enable[i] && (!tx_gap[i] || ((cyc % 3) != 0));
            if (rx_imm[i]) rv[i] = busy && !gen_clear && (rx_sent[i] < rx_limit[i]);
            else           rv[i] = pipe[4][i] && (rx_sent[i] < rx_limit[i]);
            if (gen_enable[i]) n_en[i]++;
            if (tv[i]) tx_sent[i]++;
            if (rv[i]) rx_sent[i]++;
        end
        for (int k = 4; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = tv;
        tx_beat = tv;
        rx_beat = rv;
    endtask

    task automatic set_modes(input int lim0, input int lim1, input int lim2, input int lim3);
        for (int i = 0; i < NP; i++) begin
            rx_imm[i] = 1'b0;
            tx_gap[i] = 1'b0;
        end
        rx_limit[0] = lim0;
        rx_limit[1] = lim1;
        rx_limit[2] = lim2;
        rx_limit[3] = lim3;
    endtask

    task automatic start_run(input int beats, input logic [NP-1:0] mask, input int tmo);
        cfg_beats     = CW'(beats);
        cfg_port_mask = mask;
        cfg_timeout   = TW'(tmo);
        for (int i = 0; i < NP; i++) begin
            tx_sent[i] = 0;
            rx_sent[i] = 0;
            n_en[i]    = 0;
        end
        for (int k = 0; k < 5; k++) pipe[k] = '0;
        n_clr  = 0;
        n_post = 0;
        start  = 1'b1;
        cycle();
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!done && (k < limit)) begin
            cycle();
            k++;
        end
        if (!done) check("wait_done", 64'd0, 64'd1);
    endtask

    task automatic read_stat(input logic [1:0] sel);
        stat_sel = sel;
        cycle();
    endtask

    initial begin
        bit flag37;
        bit drop_chk;
        bit pulsed;
        int k;

        for (int k2 = 0; k2 < 5; k2++) pipe[k2] = '0;
        set_modes(0, 0, 0, 0);

        // ---------------- reset state ----------------
        repeat (3) cycle();
        check("rst_gen_clear", gen_clear, 1);
        check("rst_gen_enable", gen_enable, 0);
        check("rst_busy_done", {busy, done, pass, timeout_flag}, 0);
        check("rst_fail_mask", fail_mask, 0);
        check("rst_stat", {stat_tx_count, stat_rx_count}, 0);
        axi_resetn = 1'b1;
        repeat (4) cycle();

        // ---------------- base run ----------------
        set_modes(100, 100, 0, 0);
        start_run(100, 4'b0011, 0);
        check("base_clear_busy", {busy, gen_clear}, 2'b11);
        wait_done(400);
        check("base_n_clear", n_clr, 8);
        check("base_en0", n_en[0], 100);
        check("base_en1", n_en[1], 100);
        check("base_en2", n_en[2], 0);
        check("base_drain_len", n_post, 6);
        check("base_verdict", {done, pass, timeout_flag, fail_mask}, 7'b1100000);
        read_stat(2'd0);
        check("base_stat_tx0", stat_tx_count, 100);
        read_stat(2'd1);
        check("base_stat_rx1", stat_rx_count, 100);

        // ---------------- backpressure with start ignored in RUN ----------------
        set_modes(0, 0, 37, 0);
        tx_gap[2] = 1'b1;
        start_run(37, 4'b0100, 0);
        flag37 = 1'b0; drop_chk = 1'b0; pulsed = 1'b0; k = 0;
        while (!done && (k < 400)) begin
            cycle();
            k++;
            if ((tx_sent[2] == 10) && !pulsed) begin
                cfg_beats = CW'(5);
                start     = 1'b1;
                pulsed    = 1'b1;
            end
            if (flag37 && !drop_chk) begin
                check("bp_enable_drop", gen_enable[2], 0);
                drop_chk = 1'b1;
            end
            if (tx_sent[2] == 37) flag37 = 1'b1;
        end
        check("bp_drop_seen", drop_chk, 1);
        check("bp_tx_sent", tx_sent[2], 37);
        check("bp_verdict", {done, pass, fail_mask}, 6'b110000);
        read_stat(2'd2);
        check("bp_stat_tx2", stat_tx_count, 37);

        // ---------------- checker error ----------------
        set_modes(10, 10, 0, 0);
        err_count = {8'd0, 8'd0, 8'd3, 8'd0};
        start_run(10, 4'b0011, 0);
        wait_done(200);
        check("err_fail_mask", fail_mask, 4'b0010);
        check("err_pass", {done, pass, timeout_flag}, 3'b100);
        err_count = '0;

        // ---------------- drain loss with timeout ----------------
        set_modes(99, 0, 0, 0);
        start_run(100, 4'b0001, 50);
        wait_done(400);
        check("loss_timeout", timeout_flag, 1);
        check("loss_drain_len", n_post, 51);
        check("loss_verdict", {done, pass, fail_mask}, 6'b100001);

        // ---------------- overrun ----------------
        set_modes(101, 0, 0, 0);
        rx_imm[0] = 1'b1;
        start_run(100, 4'b0001, 50);
        wait_done(400);
        check("ovr_verdict", {done, pass, timeout_flag, fail_mask}, 7'b1000001);
        read_stat(2'd0);
        check("ovr_stat_rx0", stat_rx_count, 101);

        // ---------------- zero beats ----------------
        set_modes(0, 0, 0, 0);
        start_run(0, 4'b0001, 0);
        wait_done(50);
        check("zero_n_clear", n_clr, 8);
        check("zero_en", n_en[0], 0);
        check("zero_run_drain", n_post, 2);
        check("zero_verdict", {done, pass, fail_mask}, 6'b110000);

        // ---------------- abort during RUN ----------------
        set_modes(100, 0, 0, 0);
        start_run(100, 4'b0001, 0);
        k = 0;
        while ((n_en[0] < 10) && (k < 100)) begin
            cycle();
            k++;
        end
        abort = 1'b1;
        cycle();
        check("abort_outputs", {gen_enable, gen_clear, done, busy}, 7'b0000100);
        read_stat(2'd0);
        check("abort_keep_tx", stat_tx_count, 10);

        // ---------------- async reset mid-DRAIN ----------------
        set_modes(0, 0, 0, 0);
        start_run(20, 4'b0001, 0);
        k = 0;
        while ((n_post < 5) && (k < 200)) begin
            cycle();
            k++;
        end
        check("rst_mid_in_drain", {busy, gen_clear}, 2'b10);
        #2;
        axi_resetn = 1'b0;
        #1;
        check("rst_mid_outputs", {gen_clear, gen_enable, busy, done, pass, timeout_flag}, 9'b100000000);
        check("rst_mid_stat", stat_tx_count, 0);
        repeat (2) cycle();
        axi_resetn = 1'b1;
        repeat (4) cycle();
        set_modes(20, 0, 0, 0);
        start_run(20, 4'b0001, 0);
        wait_done(200);
        check("rst_rerun_verdict", {done, pass, fail_mask}, 6'b110000);
        read_stat(2'd0);
        check("rst_rerun_tx", stat_tx_count, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
